// File: rtl/fetch_pkg.sv
// Shared entry type and branch-decode helpers for the fetch stage.
package fetch_pkg;

   localparam int ENTRY_XLEN = 32;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [ENTRY_XLEN-1:0] instr;
      logic [ENTRY_XLEN-1:0] pc;
      logic [ENTRY_XLEN-1:0] next_pc;
      logic                  pred_taken;
   } fetch_entry_t;

   // Sign-extended B-type immediate; bit 31 of the word is imm[12].
   function automatic logic [ENTRY_XLEN-1:0] b_imm(input logic [ENTRY_XLEN-1:0] instr);
      return {{(ENTRY_XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO of DEPTH entries of type T, with clear.
// Latency: a push is visible at the head one cycle later (no bypass).
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module fetch_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic [31:0]
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       push_dat,
   input  logic                   pop,
   input  logic                   clear,
   output T                       head_dat,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_DEPTH);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop)      count <= count + CNT_ONE;
         else if (do_pop && !do_push) count <= count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: issues word fetches, buffers {instr, pc, pc+4, pred} for decode.
// Latency: response enqueued at M is visible to decode at M+1; redirect target issued at N+1.
// Backpressure: requests are credit-limited so count + outstanding never exceeds DEPTH; optional FETCH_STATIC_PREDICT_EN.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int              XLEN     = ENTRY_XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_instr,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_next_pc,
   output logic            dec_pred_taken
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);
   localparam logic [CW:0]     CREDIT  = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   logic            started;
   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_nxt;
   logic [CW-1:0]   drop;
   logic [CW-1:0]   count;
   logic [CW-1:0]   pcq_count;
   logic            pcq_full;
   logic            pcq_empty;
   logic            fifo_full;
   logic            fifo_empty;
   logic            req_fire;
   logic            rsp_drop;
   logic            enq;
   logic            deq;
   logic            pred_hit;
   logic [XLEN-1:0] pred_target;
   logic [XLEN-1:0] rsp_pc;
   fetch_entry_t    enq_entry;
   fetch_entry_t    head;

   assign imem_req_valid = started && !redirect_valid &&
                           (({1'b0, count} + {1'b0, outstanding}) < CREDIT);
   assign imem_addr      = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_drop       = (drop != '0);
   assign enq            = imem_rsp_valid && !rsp_drop && !redirect_valid;
   assign deq            = dec_valid && dec_ready && !redirect_valid;

`ifdef FETCH_STATIC_PREDICT_EN
   assign pred_hit    = enq && (imem_rsp_data[6:0] == OPC_BRANCH) && imem_rsp_data[31];
   assign pred_target = rsp_pc + b_imm(imem_rsp_data);
`else
   assign pred_hit    = 1'b0;
   assign pred_target = '0;
`endif

   always_comb begin
      outstanding_nxt = outstanding;
      if (req_fire && !imem_rsp_valid)      outstanding_nxt = outstanding + CNT_ONE;
      else if (!req_fire && imem_rsp_valid) outstanding_nxt = outstanding - CNT_ONE;
   end

   // Every request still in flight after a redirect or prediction is stale,
   // including one accepted in the same cycle as a prediction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         started     <= 1'b0;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         started     <= 1'b1;
         outstanding <= outstanding_nxt;
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            drop     <= outstanding_nxt;
         end else if (pred_hit) begin
            fetch_pc <= {pred_target[XLEN-1:2], 2'b00};
            drop     <= outstanding_nxt;
         end else begin
            if (req_fire)                fetch_pc <= fetch_pc + PC_STEP;
            if (imem_rsp_valid && rsp_drop) drop  <= drop - CNT_ONE;
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_pc_q (
      .clk      (clk),
      .rst      (rst),
      .push     (req_fire),
      .push_dat (fetch_pc),
      .pop      (imem_rsp_valid),
      .clear    (1'b0),
      .head_dat (rsp_pc),
      .full     (pcq_full),
      .empty    (pcq_empty),
      .count    (pcq_count)
   );

   assign enq_entry = '{instr: imem_rsp_data, pc: rsp_pc, next_pc: rsp_pc + PC_STEP,
                        pred_taken: pred_hit};

   fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_entry_q (
      .clk      (clk),
      .rst      (rst),
      .push     (enq),
      .push_dat (enq_entry),
      .pop      (deq),
      .clear    (redirect_valid),
      .head_dat (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (count)
   );

   assign dec_valid   = !fifo_empty;
   assign dec_instr   = dec_valid ? head.instr   : '0;
   assign dec_pc      = dec_valid ? head.pc      : '0;
   assign dec_next_pc = dec_valid ? head.next_pc : '0;

`ifdef FETCH_STATIC_PREDICT_EN
   assign dec_pred_taken = dec_valid && head.pred_taken;
`else
   assign dec_pred_taken = 1'b0;
   a_no_pred: assert property (@(posedge clk) disable iff (!rst) !(dec_valid && head.pred_taken));
`endif

   a_count_max: assert property (@(posedge clk) disable iff (!rst) {1'b0, count} <= CREDIT);
   a_outst_max: assert property (@(posedge clk) disable iff (!rst) {1'b0, outstanding} <= CREDIT);
   a_pcq_sync:  assert property (@(posedge clk) disable iff (!rst) pcq_count == outstanding);
   a_pcq_push:  assert property (@(posedge clk) disable iff (!rst) !(req_fire && pcq_full));
   a_pcq_pop:   assert property (@(posedge clk) disable iff (!rst) !(imem_rsp_valid && pcq_empty));
   a_enq_room:  assert property (@(posedge clk) disable iff (!rst) !(enq && fifo_full && !deq));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a program-order reference model.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic [31:0] dec_next_pc;
   logic        dec_pred_taken;

   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_next_pc    (dec_next_pc),
      .dec_pred_taken (dec_pred_taken)
   );

   always #5 clk = ~clk;

`ifdef FETCH_STATIC_PREDICT_EN
   localparam logic        PRED_ON      = 1'b1;
   localparam logic [31:0] AFTER_BRANCH = 32'h10;
`else
   localparam logic        PRED_ON      = 1'b0;
   localparam logic [31:0] AFTER_BRANCH = 32'h24;
`endif

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] next_pc;
      logic        pred;
   } pop_t;

   mreq_t       memq[$];
   pop_t        pop_log[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          n_req = 0;
   int          n_pops = 0;
   int          first_req = -1;
   int          first_dv = -1;
   logic [31:0] first_addr = '0;
   logic        s_req_valid;
   logic [31:0] s_addr;
   int          req_pct = 100;
   int          dec_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;
   logic [31:0] exp_pc = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Instruction memory image: a backward beq (offset -16) at 0x20, distinct ALU words elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      if (a == 32'h20) return 32'hFE0008E3;
      h = {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
      return {h[31:7], 7'b0010011};
   endfunction

   function automatic logic [31:0] branch_offset(input logic [31:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic rsp_pending();
      return (memq.size() > 0) && (memq[0].due <= cyc);
   endfunction

   // Program-order reference: each accepted entry must be the next instruction of the stream.
   task automatic model_pop();
      logic [31:0] ei;
      logic        ep;
      ei = mem_word(exp_pc);
      ep = PRED_ON && (ei[6:0] == 7'b1100011) && ei[31];
      check_eq("dec_pc", dec_pc, exp_pc);
      check_eq("dec_instr", dec_instr, ei);
      check_eq("dec_next_pc", dec_next_pc, exp_pc + 32'd4);
      check_eq("dec_pred_taken", 32'(dec_pred_taken), 32'(ep));
      pop_log.push_back('{dec_pc, dec_next_pc, dec_pred_taken});
      n_pops++;
      exp_pc = ep ? exp_pc + branch_offset(ei) : exp_pc + 32'd4;
   endtask

   task automatic step(input logic redir, input logic [31:0] rpc);
      logic rsp_now;
      logic req_hs;
      logic deq_hs;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_req_ready = (int'($urandom_range(0, 99)) < req_pct);
      dec_ready      = (int'($urandom_range(0, 99)) < dec_pct);
      rsp_now        = rsp_pending();
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = 32'h0;
      if (rsp_now) imem_rsp_data = mem_word(memq[0].addr);
      #1;
      s_req_valid = imem_req_valid;
      s_addr      = imem_addr;
      req_hs      = imem_req_valid && imem_req_ready;
      deq_hs      = dec_valid && dec_ready;
      if (req_hs) begin
         check_eq("addr_align", 32'(imem_addr[1:0]), 32'd0);
         check_eq("inflight_credit", 32'(memq.size() < 4), 32'd1);
         memq.push_back('{imem_addr, cyc + int'($urandom_range(lat_min, lat_max))});
         n_req++;
         if (first_req < 0) begin
            first_req  = cyc;
            first_addr = imem_addr;
         end
      end
      if (rsp_now) void'(memq.pop_front());
      if (deq_hs && !redir) model_pop();
      if (redir) exp_pc = {rpc[31:2], 2'b00};
      if (dec_valid && first_dv < 0) first_dv = cyc;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      dec_ready      = 1'b0;
      memq.delete();
      exp_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("rst_addr", imem_addr, 32'h0);
      check_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
      check_eq("rst_dec_instr", dec_instr, 32'h0);
      check_eq("rst_dec_pc", dec_pc, 32'h0);
      check_eq("rst_dec_next_pc", dec_next_pc, 32'h0);
      check_eq("rst_dec_pred", 32'(dec_pred_taken), 32'd0);
      rst = 1'b1;
   endtask

   initial begin
      int   p0;
      int   r0;
      int   k;
      logic found;

      apply_reset();

      // Stream from reset with single-cycle memory.
      for (int i = 0; i < 30 && first_dv < 0; i++) step(1'b0, 32'h0);
      check_eq("first_req_addr", first_addr, 32'h0);
      check_eq("first_dv_latency", 32'(first_dv - first_req), 32'd2);
      p0 = n_pops;
      repeat (6) step(1'b0, 32'h0);
      check_eq("stream_rate", 32'(n_pops - p0), 32'd6);
      for (int i = 0; i < 3; i++) check_eq("stream_pc", pop_log[i].pc, 32'(4 * i));

      // Backpressure: decode stalled after a redirect fills exactly DEPTH entries.
      dec_pct = 0;
      step(1'b1, 32'h200);
      r0 = n_req;
      repeat (12) step(1'b0, 32'h0);
      check_eq("bp_req_total", 32'(n_req - r0), 32'd4);
      check_eq("bp_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("bp_dec_valid", 32'(dec_valid), 32'd1);
      pop_log.delete();
      dec_pct = 100;
      repeat (10) step(1'b0, 32'h0);
      for (int i = 0; i < 5; i++) check_eq("bp_drain_pc", pop_log[i].pc, 32'h200 + 32'(4 * i));

      // Redirect with three requests in flight at latency 3.
      lat_min = 3;
      lat_max = 3;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (memq.size() == 3) found = 1'b1;
         else step(1'b0, 32'h0);
      end
      check_eq("rd_three_inflight", 32'(found), 32'd1);
      step(1'b1, 32'h100);
      step(1'b0, 32'h0);
      check_eq("rd_next_req_valid", 32'(s_req_valid), 32'd1);
      check_eq("rd_next_req_addr", s_addr, 32'h100);
      pop_log.delete();
      for (int i = 0; i < 50 && pop_log.size() == 0; i++) step(1'b0, 32'h0);
      check_eq("rd_first_pc", pop_log[0].pc, 32'h100);

      // Redirect in the same cycle as a response and a dequeue.
      lat_min = 1;
      lat_max = 1;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (rsp_pending() && dec_valid) found = 1'b1;
         else step(1'b0, 32'h0);
      end
      check_eq("rd3_setup", 32'(found), 32'd1);
      step(1'b1, 32'h300);
      check_eq("rd3_empty_next", 32'(dec_valid), 32'd0);
      pop_log.delete();
      for (int i = 0; i < 50 && pop_log.size() == 0; i++) step(1'b0, 32'h0);
      check_eq("rd3_first_pc", pop_log[0].pc, 32'h300);

      // Backward branch at 0x20.
      pop_log.delete();
      step(1'b1, 32'h18);
      repeat (20) step(1'b0, 32'h0);
      k = -1;
      for (int i = 0; i < pop_log.size() && k < 0; i++) if (pop_log[i].pc == 32'h20) k = i;
      check_eq("br_seen", 32'(k >= 0 && k + 1 < pop_log.size()), 32'd1);
      if (k >= 0 && k + 1 < pop_log.size()) begin
         check_eq("br_pred_taken", 32'(pop_log[k].pred), 32'(PRED_ON));
         check_eq("br_after_pc", pop_log[k + 1].pc, AFTER_BRANCH);
      end

      // Address wrap-around.
      pop_log.delete();
      step(1'b1, 32'hFFFF_FFF8);
      repeat (10) step(1'b0, 32'h0);
      check_eq("wrap_pc0", pop_log[0].pc, 32'hFFFF_FFF8);
      check_eq("wrap_pc1", pop_log[1].pc, 32'hFFFF_FFFC);
      check_eq("wrap_next1", pop_log[1].next_pc, 32'h0);
      check_eq("wrap_pc2", pop_log[2].pc, 32'h0);

      // Random traffic with redirects and one asynchronous mid-run reset.
      req_pct = 75;
      dec_pct = 70;
      lat_min = 1;
      lat_max = 4;
      p0 = n_pops;
      for (int c = 0; c < 4000; c++) begin
         if (c == 2000) apply_reset();
         if ($urandom_range(0, 49) == 0) step(1'b1, 32'($urandom_range(0, 255)) << 2);
         else step(1'b0, 32'h0);
      end
      check_eq("random_progress", 32'(n_pops - p0 > 500), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised, decoupled instruction-fetch stage for the RISC-V pipeline, sitting between the program counter and the decode stage. It issues word-aligned fetches to an instruction memory through a valid/ready request port, accepts in-order responses of any latency, and buffers up to DEPTH fetched instructions (with their PC and PC+4) in a FIFO. Decode drains the FIFO through a valid/ready handshake. Execute-stage redirects flush the FIFO and discard stale in-flight responses.

## Interface
- XLEN, 32: PC and instruction width.
- DEPTH, 4: FIFO entries and the maximum number of in-flight requests. Must be a power of two and at least 2.
- RESET_PC, 0: PC fetched first after reset.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- redirect_valid  in  1  execute-stage redirect (taken branch or jump).
- redirect_pc  in  XLEN  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  XLEN  fetch address; bits [1:0] are always 0.
- imem_rsp_valid  in  1  response valid; responses arrive in request order.
- imem_rsp_data  in  XLEN  instruction word.
- dec_valid  out  1  FIFO head is valid.
- dec_ready  in  1  decode consumes the head.
- dec_instr  out  XLEN  head instruction.
- dec_pc  out  XLEN  head PC.
- dec_next_pc  out  XLEN  head PC+4.
- dec_pred_taken  out  1  head was predicted taken (0 when FETCH_STATIC_PREDICT_EN is undefined).

## Operation
- **Reset values:**
  - fetch_pc = RESET_PC.
  - FIFO empty and dec_valid = 0.
  - Outstanding count = 0 and drop count = 0.
  - imem_req_valid = 0.
  - All dec_* data outputs = 0.
- **Request issue:**
  - imem_req_valid = 1 when count + outstanding < DEPTH and no redirect is asserted this cycle.
  - imem_addr = fetch_pc.
  - On a request handshake: fetch_pc <= fetch_pc + 4 (modulo 2^XLEN) and outstanding increments.
- **Response handling:**
  - Every imem_rsp_valid decrements outstanding.
  - If drop count > 0, the response is discarded and drop count decrements.
  - Otherwise {data, pc, pc+4, pred} is enqueued. The PC for each entry comes from a DEPTH-deep in-flight PC queue written at issue.
- **Dequeue:** a dec_valid && dec_ready handshake pops the head.
- **Redirect:**
  - fetch_pc <= redirect_pc and the FIFO is cleared.
  - drop count <= outstanding, minus 1 if a response arrives in the same cycle.
  - Any request or dequeue handshake in the redirect cycle is void: fetch_pc is not incremented and the void request is not counted. The memory still returns a response for it, so it is added to the drop count.
- **Simultaneous events:**
  - redirect overrides prediction, enqueue and dequeue.
  - Enqueue and dequeue in the same cycle keep count unchanged.
  - A full FIFO with dec_ready = 1 and an incoming response is legal, because credit guarantees a free slot after the pop.
- **Counter width:** count and outstanding are $clog2(DEPTH)+1 bits. Neither may exceed DEPTH; assertions check this.

## Timing
- Enqueue at cycle M gives dec_valid = 1 at M+1. There is no bypass.
- redirect_valid at cycle N gives imem_req_valid with imem_addr = redirect_pc at N+1 at the earliest.
- Throughput is one instruction per cycle with single-cycle memory and DEPTH ≥ 2.
- Reset asserted mid-operation clears state asynchronously. Responses still in flight afterwards are ignored: the bench must not return responses to pre-reset requests.

## Configuration
- **FETCH_STATIC_PREDICT_EN defined:** backward-taken/forward-not-taken static prediction is applied to each enqueued response.
  - Trigger: opcode 1100011 (B-type) with imm[12] = 1.
  - The entry gets pred_taken = 1.
  - fetch_pc <= pc + sext(B-imm).
  - drop count <= outstanding after this response; the FIFO is not flushed.
  - An external redirect in the same cycle wins.
- **FETCH_STATIC_PREDICT_EN undefined:** the predictor logic is absent and dec_pred_taken is tied to 0.

## Structure
- **Shared package fetch_pkg:**
  - Entry struct {instr, pc, next_pc, pred_taken}.
  - Opcode constant OPC_BRANCH = 7'b1100011.
  - Function b_imm(instr).
- **Sub-module fetch_fifo:** a parametrised sync FIFO (DEPTH, entry type) with push, pop, clear, full, empty and count. It is instantiated for both the entry FIFO and the in-flight PC queue.

## Test plan
- **Reset and stream:** release reset with single-cycle memory and dec_ready = 1 → requests at 0x0, 0x4, 0x8…; dec_valid first high 2 cycles after the first request; one pop per cycle.
- **Backpressure:** hold dec_ready = 0 → FIFO fills to DEPTH = 4; imem_req_valid drops with exactly 4 in flight plus queued in total; no entry is lost or duplicated when dec_ready is released.
- **Redirect with in-flight requests:** memory latency 3, redirect to 0x100 with 3 outstanding → the 3 stale responses are dropped; the first dec_pc after the redirect is 0x100.
- **Redirect simultaneous with response and dequeue:** fire all three in one cycle → the FIFO is empty the next cycle, drop count is correct, and the next dec_pc is the redirect target.
- **Static prediction (FETCH_STATIC_PREDICT_EN):** a beq at 0x20 with offset −16 → dec_pred_taken = 1 and the next fetch is 0x10; the younger fetch at 0x24 is dropped. With the macro undefined, the next fetch is 0x24 and dec_pred_taken = 0.
- **Wrap-around:** RESET_PC = 0xFFFFFFF8 → fetches at 0xFFFFFFF8, 0xFFFFFFFC, 0x0; dec_next_pc for 0xFFFFFFFC is 0x0.
